present_key_stream: RTL and testbench

//  Sequential PRESENT round-key generator, parametrised for 80- or 128-bit keys.

---
 rtl/present_key_stream_pkg.sv | 42 ++++
 rtl/present_key_stream_step.sv | 57 +++++
 rtl/present_key_stream.sv | 104 ++++++++++
 tb/tb_present_key_stream.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/present_key_stream_pkg.sv
// rtl/present_key_stream_pkg.sv - shared PRESENT key-schedule definitions
// Contents:
//   state_t           FSM encoding used by present_key_stream
//   PRESENT_RK_W      round-key width (64)
//   KEY_W_80/128      the two legal master-key widths
//   present_sbox      4-bit PRESENT S-box
//   present_sbox_inv  4-bit inverse PRESENT S-box
package present_key_stream_pkg;

  localparam int PRESENT_RK_W = 64;
  localparam int KEY_W_80     = 80;
  localparam int KEY_W_128    = 128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREROLL = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  function automatic logic [3:0] present_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] present_sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/present_key_stream_step.sv
// rtl/present_key_stream_step.sv - one combinational PRESENT key-schedule step
// Ports:
//   key       in   KEY_W  current key register
//   c         in   5      round counter mixed into the key
//   dir       in   1      0 = forward step (i -> i+1), 1 = inverse step (i+1 -> i)
//   key_next  out  KEY_W  key after the step
module present_key_stream_step
  import present_key_stream_pkg::*;
#(
  parameter int KEY_W = 80
) (
  input  logic [KEY_W-1:0] key,
  input  logic [4:0]       c,
  input  logic             dir,
  output logic [KEY_W-1:0] key_next
);

  logic [KEY_W-1:0] fwd;
  logic [KEY_W-1:0] inv;

  generate
    if (KEY_W == KEY_W_128) begin : g_128
      logic [KEY_W-1:0] rot;
      logic [KEY_W-1:0] unx;
      always_comb begin
        // forward: rotl 61, two S-boxes on the top byte, counter into [66:62]
        rot            = {key[66:0], key[127:67]};
        fwd            = rot;
        fwd[127:124]   = present_sbox(rot[127:124]);
        fwd[123:120]   = present_sbox(rot[123:120]);
        fwd[66:62]     = rot[66:62] ^ c;
        // inverse: undo the operations in reverse order, then rotr 61
        unx            = key;
        unx[66:62]     = key[66:62] ^ c;
        unx[127:124]   = present_sbox_inv(key[127:124]);
        unx[123:120]   = present_sbox_inv(key[123:120]);
        inv            = {unx[60:0], unx[127:61]};
      end
    end else begin : g_80
      logic [KEY_W-1:0] rot;
      logic [KEY_W-1:0] unx;
      always_comb begin
        rot          = {key[18:0], key[KEY_W_80-1:19]};
        fwd          = rot;
        fwd[79:76]   = present_sbox(rot[79:76]);
        fwd[19:15]   = rot[19:15] ^ c;
        unx          = key;
        unx[19:15]   = key[19:15] ^ c;
        unx[79:76]   = present_sbox_inv(key[79:76]);
        inv          = {unx[60:0], unx[KEY_W_80-1:61]};
      end
    end
  endgenerate

  assign key_next = dir ? inv : fwd;

endmodule

// File: rtl/present_key_stream.sv
// rtl/present_key_stream.sv - sequential PRESENT round-key stream generator
// Ports:
//   clk         in   1      clock
//   rst         in   1      asynchronous reset, active-high
//   key_in      in   KEY_W  master key, sampled on load handshake
//   dec         in   1      0 = K1..K(ROUNDS+1), 1 = K(ROUNDS+1)..K1
//   load_valid  in   1      key_in/dec valid
//   load_ready  out  1      accepting a load (IDLE only)
//   rk          out  64     current round key (top 64 bits of key_reg)
//   rk_idx      out  5      1-based index of rk (K32 reports 0)
//   rk_last     out  1      rk is the final key of the stream
//   rk_valid    out  1      rk/rk_idx/rk_last valid
//   rk_ready    in   1      consumer accepts rk
//   busy        out  1      not IDLE
module present_key_stream
  import present_key_stream_pkg::*;
#(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             dec,
  input  logic             load_valid,
  output logic             load_ready,
  output logic [63:0]      rk,
  output logic [4:0]       rk_idx,
  output logic             rk_last,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             busy
);

  localparam logic [5:0] LAST_IDX   = 6'(ROUNDS + 1);
  localparam logic [5:0] ROUNDS_IDX = 6'(ROUNDS);

  state_t           state;
  logic [KEY_W-1:0] key_reg;
  logic [KEY_W-1:0] key_nxt;
  // 6 bits so that K32 does not wrap idx back to zero internally
  logic [5:0]       idx;
  logic [5:0]       idx_m1;
  logic             dec_reg;
  logic             step_dir;
  logic [4:0]       step_c;

  // PREROLL always steps forward; EMIT follows the stream direction.
  // The inverse step from state i+1 uses counter i, hence idx-1.
  assign idx_m1   = idx - 6'd1;
  assign step_dir = (state == ST_EMIT) && dec_reg;
  assign step_c   = step_dir ? idx_m1[4:0] : idx[4:0];

  present_key_stream_step #(.KEY_W(KEY_W)) u_step (
    .key      (key_reg),
    .c        (step_c),
    .dir      (step_dir),
    .key_next (key_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      key_reg <= '0;
      idx     <= '0;
      dec_reg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_valid) begin
            key_reg <= key_in;
            idx     <= 6'd1;
            dec_reg <= dec;
            state   <= dec ? ST_PREROLL : ST_EMIT;
          end
        end
        ST_PREROLL: begin
          key_reg <= key_nxt;
          idx     <= idx + 6'd1;
          if (idx == ROUNDS_IDX) state <= ST_EMIT;
        end
        ST_EMIT: begin
          if (rk_ready) begin
            if (rk_last) begin
              state <= ST_IDLE;
            end else begin
              key_reg <= key_nxt;
              idx     <= dec_reg ? idx_m1 : idx + 6'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign load_ready = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign rk_valid   = (state == ST_EMIT);
  assign rk         = key_reg[KEY_W-1 -: PRESENT_RK_W];
  assign rk_idx     = idx[4:0];
  assign rk_last    = (state == ST_EMIT) && (dec_reg ? (idx == 6'd1) : (idx == LAST_IDX));

endmodule

// File: tb/tb_present_key_stream.sv
// tb/tb_present_key_stream.sv - self-checking bench for present_key_stream (80 and 128 bit)
module tb_present_key_stream;

  localparam int ROUNDS = 31;
  localparam int NK     = ROUNDS + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [79:0]  key80;
  logic [127:0] key128;
  logic         dec, load_valid, rk_ready;
  logic         lr80, lr128, last80, last128, v80, v128, busy80, busy128;
  logic [63:0]  rk80, rk128;
  logic [4:0]   idx80, idx128;

  always #5 clk = ~clk;

  present_key_stream #(.KEY_W(80), .ROUNDS(ROUNDS)) dut80 (
    .clk(clk), .rst(rst), .key_in(key80), .dec(dec), .load_valid(load_valid),
    .load_ready(lr80), .rk(rk80), .rk_idx(idx80), .rk_last(last80),
    .rk_valid(v80), .rk_ready(rk_ready), .busy(busy80));

  present_key_stream #(.KEY_W(128), .ROUNDS(ROUNDS)) dut128 (
    .clk(clk), .rst(rst), .key_in(key128), .dec(dec), .load_valid(load_valid),
    .load_ready(lr128), .rk(rk128), .rk_idx(idx128), .rk_last(last128),
    .rk_valid(v128), .rk_ready(rk_ready), .busy(busy128));

  typedef struct packed {
    logic [63:0] rk;
    logic [4:0]  idx;
    logic        last;
  } beat_t;

  beat_t       q80[$];
  beat_t       q128[$];
  logic [63:0] got80[$];
  logic [63:0] got128[$];

  int checks = 0;
  int errors = 0;

  logic [63:0] sbox_t = 64'h21748FE3DA09B65C;
  logic [63:0] sinv_t = 64'hA970364BD21C8FE5;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sb(input logic [3:0] x);
    return sbox_t[4*int'(x) +: 4];
  endfunction

  // reference schedule step on a 128-bit container; w selects 80 or 128
  function automatic logic [127:0] mstep(input logic [127:0] k, input int w, input int c);
    logic [127:0] r;
    logic [4:0]   c5;
    c5 = c[4:0];
    if (w == 80) begin
      r = ((k << 61) | (k >> 19)) & {48'h0, {80{1'b1}}};
      r[79:76] = sb(r[79:76]);
      r[19:15] = r[19:15] ^ c5;
    end else begin
      r = (k << 61) | (k >> 67);
      r[127:124] = sb(r[127:124]);
      r[123:120] = sb(r[123:120]);
      r[66:62] = r[66:62] ^ c5;
    end
    return r;
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] s, input logic [63:0] tbl);
    logic [63:0] o;
    for (int i = 0; i < 16; i++) o[4*i +: 4] = tbl[4*int'(s[4*i +: 4]) +: 4];
    return o;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] o;
    for (int i = 0; i < 63; i++) o[(16*i) % 63] = s[i];
    o[63] = s[63];
    return o;
  endfunction

  function automatic logic [63:0] p_inv(input logic [63:0] s);
    logic [63:0] o;
    for (int i = 0; i < 63; i++) o[i] = s[(16*i) % 63];
    o[63] = s[63];
    return o;
  endfunction

  task automatic push_expected(input logic [127:0] k, input logic d);
    logic [63:0]  a80[NK];
    logic [63:0]  a128[NK];
    logic [127:0] s80, s128;
    s80  = {48'h0, k[79:0]};
    s128 = k;
    for (int i = 0; i < NK; i++) begin
      a80[i]  = s80[79:16];
      a128[i] = s128[127:64];
      s80  = mstep(s80, 80, i + 1);
      s128 = mstep(s128, 128, i + 1);
    end
    for (int j = 0; j < NK; j++) begin
      int i;
      int n;
      i = d ? NK - 1 - j : j;
      n = i + 1;
      q80.push_back(beat_t'{rk: a80[i], idx: 5'(n), last: d ? (n == 1) : (n == NK)});
      q128.push_back(beat_t'{rk: a128[i], idx: 5'(n), last: d ? (n == 1) : (n == NK)});
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rk"},    128'({rk80, rk128}), 128'd0);
    chk({tag, "_idx"},   128'({idx80, idx128}), 128'd0);
    chk({tag, "_flags"}, 128'({last80, v80, busy80, lr80, last128, v128, busy128, lr128}),
        128'(8'b0001_0001));
  endtask

  // load a key, then drain the stream against the scoreboard
  task automatic run_stream(input logic [127:0] k, input logic d, input int rdy_pct, input bit noise);
    int   cyc;
    beat_t e;
    got80.delete();
    got128.delete();
    push_expected(k, d);
    key80 = k[79:0]; key128 = k; dec = d; load_valid = 1'b1; rk_ready = 1'b0;
    chk("load_ready_idle", 128'({lr80, lr128}), 128'(2'b11));
    @(posedge clk); #1;
    load_valid = 1'b0; dec = ~d;
    cyc = 1;
    while (!v80 && cyc < NK + 4) begin
      chk("busy_preroll", 128'({busy80, busy128, lr80, lr128}), 128'(4'b1100));
      if (noise) begin
        load_valid = ($urandom_range(1) == 1);
        key80 = ~k[79:0]; key128 = ~k;
      end
      @(posedge clk); #1;
      cyc++;
    end
    load_valid = 1'b0;
    chk("latency", 128'(cyc), 128'(d ? NK : 1));
    cyc = 0;
    while (q80.size() > 0 && cyc < 400) begin
      rk_ready = ($urandom_range(99) < rdy_pct);
      if (noise) begin
        load_valid = ($urandom_range(3) == 0);
        key80 = ~k[79:0]; key128 = ~k;
      end
      chk("rk_valid", 128'({v80, v128}), 128'(2'b11));
      chk("load_ready_busy", 128'({lr80, lr128}), 128'd0);
      e = q80[0];
      chk("rk80", 128'(rk80), 128'(e.rk));
      chk("idx80", 128'({idx80, last80}), 128'({e.idx, e.last}));
      e = q128[0];
      chk("rk128", 128'(rk128), 128'(e.rk));
      chk("idx128", 128'({idx128, last128}), 128'({e.idx, e.last}));
      if (rk_ready) begin
        got80.push_back(rk80);
        got128.push_back(rk128);
        void'(q80.pop_front());
        void'(q128.pop_front());
      end
      @(posedge clk); #1;
      cyc++;
    end
    rk_ready = 1'b0; load_valid = 1'b0;
    chk("stream_drained", 128'(q80.size()), 128'd0);
    chk("idle_after", 128'({v80, busy80, lr80, v128, busy128, lr128}), 128'(6'b001_001));
    q80.delete();
    q128.delete();
  endtask

  task automatic reset_mid(input logic [127:0] k, input logic d, input int wait_cyc);
    key80 = k[79:0]; key128 = k; dec = d; load_valid = 1'b1; rk_ready = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    repeat (wait_cyc) @(posedge clk);
    #1;
    chk("busy_before_rst", 128'({busy80, busy128}), 128'(2'b11));
    rst = 1'b1;
    #1;
    chk_reset_outputs(d ? "rst_preroll" : "rst_emit");
    rk_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [127:0] rk_key;
    logic [63:0]  s;
    rst = 1'b1; key80 = '0; key128 = '0; dec = 1'b0; load_valid = 1'b0; rk_ready = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // zero key, forward: known K1/K2 and PRESENT-80 test vector
    run_stream(128'd0, 1'b0, 100, 1'b0);
    chk("k1_80",  128'(got80.size() > 1 ? got80[0] : 64'hdead), 128'h0);
    chk("k2_80",  128'(got80.size() > 1 ? got80[1] : 64'hdead), 128'(64'hC000000000000000));
    chk("k2_128", 128'(got128.size() > 1 ? got128[1] : 64'hdead), 128'(64'hCC00000000000000));
    s = '1;
    if (got80.size() == NK) begin
      s = 64'h0;
      for (int r = 0; r < ROUNDS; r++) s = p_layer(s_layer(s ^ got80[r], sbox_t));
      s = s ^ got80[ROUNDS];
    end
    chk("ct80", 128'(s), 128'(64'h5579C1387B228445));

    // zero key, reverse: decrypt the known ciphertext back to zero
    run_stream(128'd0, 1'b1, 100, 1'b0);
    s = '1;
    if (got80.size() == NK) begin
      s = 64'h5579C1387B228445 ^ got80[0];
      for (int j = 1; j < NK; j++) s = s_layer(p_inv(s), sinv_t) ^ got80[j];
    end
    chk("pt80", 128'(s), 128'h0);

    // random key both directions with throttling and stray loads
    rk_key = {$urandom, $urandom, $urandom, $urandom};
    run_stream(rk_key, 1'b0, 50, 1'b1);
    run_stream(rk_key, 1'b1, 60, 1'b1);
    rk_key = {$urandom, $urandom, $urandom, $urandom};
    run_stream(rk_key, 1'b1, 100, 1'b0);

    // reset mid-preroll and mid-emit, then a clean restart
    reset_mid({$urandom, $urandom, $urandom, $urandom}, 1'b1, 10);
    reset_mid({$urandom, $urandom, $urandom, $urandom}, 1'b0, 5);
    rk_key = {$urandom, $urandom, $urandom, $urandom};
    run_stream(rk_key, 1'b0, 100, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
